// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serializer feeding the 1011 detector.
package seq_det_pkg;

  // Serializer FSM: waiting for a word, or shifting one out.
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Widest word the serializer can be built for.
  localparam int SER_MAX_WIDTH = 32;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out signal bundle for seq_bit_serializer.
//
// Handshakes:
//   word side: a word transfers on a rising clk edge where data_valid && data_ready.
//              The source holds data_valid and data_in stable until that edge;
//              data_valid without data_ready is ignored.
//   bit side:  bit_out is consumed on a rising clk edge where bit_valid && bit_en.
//              With bit_en low the current bit is held unchanged.
interface seq_bit_serializer_if
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             bit_en;
  logic             bit_out;
  logic             bit_valid;
  logic             word_done;

  // Upstream word source and downstream consumer.
  modport master (
    output data_in, data_valid, bit_en,
    input  data_ready, bit_out, bit_valid, word_done
  );

  // The serializer itself.
  modport slave (
    input  data_in, data_valid, bit_en,
    output data_ready, bit_out, bit_valid, word_done
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter ahead of the 1011 detector. Words that arrive
// back to back are shifted out with no idle cycle between them, so a pattern
// that straddles a word boundary still reaches the detector contiguously.
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,    // asynchronous, active low
  seq_bit_serializer_if.slave  bus,
  output ser_state_t           state_o   // FSM state, for debug and checkers
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SER_MAX_WIDTH) begin : g_bad_width
    $error("seq_bit_serializer: WIDTH %0d outside 2..%0d", WIDTH, SER_MAX_WIDTH);
  end

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_done_q, word_done_d;

  logic             head;
  logic [WIDTH-1:0] shreg_next;
  logic             consume;
  logic             last_bit;
  logic             ready;
  logic             accept;

  // Head bit and one-step shift in the configured direction; bits always come
  // from the shift register, never straight from data_in.
  always_comb begin
    head       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    shreg_next = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                           : {1'b0, shreg_q[WIDTH-1:1]};
  end

  // Ready when idle, or in the same cycle the last bit of the current word is
  // consumed. This is a deliberate combinational path from bit_en and reset to
  // data_ready: it is what lets the next word follow with zero bubble.
  always_comb begin
    consume  = (state_q == SER_SHIFT) && bus.bit_en;
    last_bit = consume && (cnt_q == CNT_LAST);
    ready    = reset && ((state_q == SER_IDLE) || last_bit);
    accept   = bus.data_valid && ready;
  end

  // Next-state logic: load on accept, shift on each consumed bit, chain or idle
  // once the last bit goes.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (accept) begin
          shreg_d = bus.data_in;
          cnt_d   = '0;
          state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (consume) begin
          if (!last_bit) begin
            shreg_d = shreg_next;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            word_done_d = 1'b1;
            cnt_d       = '0;
            if (accept) begin
              shreg_d = bus.data_in;
            end else begin
              shreg_d = '0;
              state_d = SER_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = SER_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, shift register, counter and done pulse; reset drops any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SER_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  // Outputs follow the registered state, so reset returns them to idle at once.
  always_comb begin
    bus.data_ready = ready;
    bus.bit_valid  = (state_q == SER_SHIFT);
    bus.bit_out    = (state_q == SER_SHIFT) ? head : IDLE_BIT;
    bus.word_done  = word_done_q;
    state_o        = state_q;
  end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream stage of seq_det_1011. Accepts parallel words over a valid/ready handshake and shifts them out one bit per advance strobe.
- Its bit_out drives the detector's serial in; bit_valid marks which cycles carry payload.
- Supports back-to-back words with zero bubble, so patterns that straddle word boundaries (e.g. 10|11) reach the detector contiguously.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit data_in[WIDTH-1] first; 0 = transmit data_in[0] first.
- IDLE_BIT, 1'b0, value driven on bit_out when no word is in flight.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel word to serialize.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  block can accept a word this cycle.
- bit_en  input  1  downstream advance strobe; the current bit is consumed when bit_valid && bit_en.
- bit_out  output  1  serial bit; connects to the detector's in.
- bit_valid  output  1  bit_out carries payload.
- word_done  output  1  one-cycle pulse, registered, in the cycle after the last bit of a word is consumed.

Behaviour:
- Reset (reset==0, async):
  - state=SER_IDLE, shift register=0, bit counter=0.
  - bit_out=IDLE_BIT, bit_valid=0, word_done=0.
  - data_ready is forced 0 combinationally while reset is low.
- States (ser_state_t): SER_IDLE, SER_SHIFT.
- SER_IDLE:
  - bit_valid=0, bit_out=IDLE_BIT, data_ready=1.
  - On data_valid && data_ready: load data_in into the shift register, cnt=0, go to SER_SHIFT.
  - The first bit appears on bit_out in the next cycle (latency 1 from the accept edge).
- SER_SHIFT:
  - bit_valid=1; bit_out = current head bit (MSB or LSB per MSB_FIRST); it is a registered/shift-register output, not a mux of data_in.
  - bit_en==0: hold everything; bit_out stays stable.
  - bit_en==1 && cnt<WIDTH-1: shift by one, cnt++.
  - bit_en==1 && cnt==WIDTH-1: last bit consumed; word_done pulses next cycle.
    - If data_valid is also high, load the new word, cnt=0, stay in SER_SHIFT. The next cycle shows the new word's first bit, so the bit stream is contiguous.
    - Else go to SER_IDLE.
- data_ready = reset && (state==SER_IDLE || (state==SER_SHIFT && cnt==WIDTH-1 && bit_en)).
  - This is a combinational path from bit_en and reset to data_ready; it is intentional and documented.
- data_valid while data_ready==0: ignored. The upstream source must hold data_valid/data_in stable until the handshake completes.
- cnt width is $clog2(WIDTH); cnt never exceeds WIDTH-1 and has no wrap beyond that.
- Reset asserted mid-word: the word is discarded, no word_done is produced, and the block returns to idle outputs immediately (async).
- word_done is never asserted for a word that was not fully consumed.

Decomposition:
- Shared package seq_det_pkg:
  - ser_state_t enum {SER_IDLE, SER_SHIFT}.
  - Constant SER_MAX_WIDTH=32 for the parameter range check.
- No sub-module: a single always_ff holds state, shift register and counter; a small always_comb produces data_ready.
- An elaboration-time assertion rejects WIDTH outside 2..SER_MAX_WIDTH.

Test Plan:
- WIDTH=4, MSB_FIRST=1, bit_en=1; single word 4'b1011 → bit_out 1,0,1,1 on cycles 1..4 after accept, bit_valid high exactly 4 cycles, word_done pulse on cycle 5. With seq_det_1011 attached, the detector's out asserts for the final 1.
- Back-to-back words 4'b0010 then 4'b1100, data_valid held → data_ready high in the last-bit cycle of word 1; bit stream 0,0,1,0,1,1,0,0 with no gap; the detector sees 1011 across the boundary; two word_done pulses 4 cycles apart.
- bit_en pattern 1,0,0,1,1,0,1 on word 4'b1011 → each bit holds while bit_en=0; bits consumed in order 1,0,1,1; data_ready rises only in the cycle with the 4th consumed bit_en=1.
- MSB_FIRST=0, word 4'b1101 → bit_out 1,0,1,1 (LSB first).
- Reset pulsed low for 1 ns after bit 2 of 4'b1011 → bit_valid=0 and bit_out=IDLE_BIT immediately; no word_done; data_ready=0 during reset and 1 after release; the next word 4'b1111 serializes cleanly.
- data_valid asserted while busy mid-word (cnt=1) → word not accepted and data_in change not reflected; accepted only at the cnt==WIDTH-1 && bit_en cycle.
